// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and opcode classification helpers.
package alu_pkg;

    localparam logic [3:0] OP_MOV      = 4'b0000;
    localparam logic [3:0] OP_NOT      = 4'b0001;
    localparam logic [3:0] OP_ADD      = 4'b0010;
    localparam logic [3:0] OP_SUB      = 4'b0011;
    localparam logic [3:0] OP_OR       = 4'b0100;
    localparam logic [3:0] OP_AND      = 4'b0101;
    localparam logic [3:0] OP_SLTU     = 4'b0110;
    localparam logic [3:0] OP_SLT      = 4'b0111;
    localparam logic [3:0] OP_SLL      = 4'b1000;
    localparam logic [3:0] OP_LI       = 4'b1001;
    localparam logic [3:0] OP_LUI      = 4'b1010;
    localparam logic [3:0] OP_SRL      = 4'b1011;
    localparam logic [3:0] OP_MUL      = 4'b1100;
    localparam logic [3:0] OP_DIVU     = 4'b1101;
    localparam logic [3:0] OP_REMU     = 4'b1110;
    localparam logic [3:0] OP_RESERVED = 4'b1111;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIter   = 2'd1,
        StFinish = 2'd2
    } state_e;

    // Ops that need the iterative engine (unless a divide hits B==0).
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Bit-serial engine: shift-add multiply or restoring divide, one bit per step.
// The *_o outputs show the value the registers will hold after the current
// step, so the caller can capture the final answer on the last step edge.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] product_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    // acc: product accumulator (mul) or partial remainder (div)
    // x:   multiplier shifting right (mul) or dividend/quotient shifting left (div)
    // y:   multiplicand shifting left (mul) or fixed divisor (div)
    logic [WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0] x_q, x_d, x_step;
    logic [WIDTH-1:0] y_q, y_d, y_step;
    logic             div_q, div_d;
    logic [WIDTH:0]   rshift;

    // One iteration of the selected algorithm.
    always_comb begin
        acc_step = acc_q;
        x_step   = x_q;
        y_step   = y_q;
        rshift   = {acc_q, x_q[WIDTH-1]};
        if (div_q) begin
            if (rshift >= {1'b0, y_q}) begin
                // True difference is below y, so W-bit wraparound is exact.
                acc_step = rshift[WIDTH-1:0] - y_q;
                x_step   = {x_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = rshift[WIDTH-1:0];
                x_step   = {x_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = x_q[0] ? (acc_q + y_q) : acc_q;
            x_step   = x_q >> 1;
            y_step   = y_q << 1;
        end
    end

    // Next-state selection: load wins over step.
    always_comb begin
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
        div_d = div_q;
        if (load_i) begin
            acc_d = '0;
            x_d   = a_i;
            y_d   = b_i;
            div_d = div_i;
        end else if (step_i) begin
            acc_d = acc_step;
            x_d   = x_step;
            y_d   = y_step;
        end
    end

    // Engine state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            div_q <= div_d;
        end
    end

    assign product_o   = acc_step;
    assign quotient_o  = x_step;
    assign remainder_o = acc_step;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ops finish in one cycle, mul/divu/remu iterate
// WIDTH cycles through alu_iter_muldiv.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             eq,
    output logic             err
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned HALF    = WIDTH / 2;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             eq_q, eq_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic             eng_load, eng_step, eng_div;
    logic [WIDTH-1:0] eng_product, eng_quotient, eng_remainder;
    logic [WIDTH-1:0] sc_result;
    logic             sc_err;
    logic             iter_req;

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (eng_load),
        .step_i      (eng_step),
        .div_i       (eng_div),
        .a_i         (a_in),
        .b_i         (b_in),
        .product_o   (eng_product),
        .quotient_o  (eng_quotient),
        .remainder_o (eng_remainder)
    );

    // Single-cycle results, including the divide-by-zero and reserved shortcuts.
    always_comb begin
        sc_result = result_q;
        sc_err    = 1'b0;
        unique case (op)
            OP_MOV:  sc_result = a_in;
            OP_NOT:  sc_result = ~a_in;
            OP_ADD:  sc_result = a_in + b_in;
            OP_SUB:  sc_result = a_in - b_in;
            OP_OR:   sc_result = a_in | b_in;
            OP_AND:  sc_result = a_in & b_in;
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
            OP_SLL:  sc_result = a_in << b_in[SHAMT_W-1:0];
            OP_SRL:  sc_result = a_in >> b_in[SHAMT_W-1:0];
            OP_LI:   sc_result = {result_q[WIDTH-1:HALF], b_in[HALF-1:0]};
            OP_LUI:  sc_result = {b_in[HALF-1:0], result_q[HALF-1:0]};
            OP_MUL:  sc_result = result_q;
            OP_DIVU: begin
                sc_result = '1;
                sc_err    = 1'b1;
            end
            OP_REMU: begin
                sc_result = a_in;
                sc_err    = 1'b1;
            end
            OP_RESERVED: begin
                sc_result = result_q;
                sc_err    = 1'b1;
            end
            default: sc_result = result_q;
        endcase
    end

    assign iter_req = is_iter_op(op) && !(is_div_op(op) && (b_in == '0));

    // FSM next state, operand capture and output updates.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        eq_d     = eq_q;
        err_d    = err_q;
        done_d   = 1'b0;
        eng_load = 1'b0;
        eng_step = 1'b0;
        eng_div  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d = op;
                    a_d  = a_in;
                    b_d  = b_in;
                    if (iter_req) begin
                        eng_load = 1'b1;
                        eng_div  = is_div_op(op);
                        cnt_d    = '0;
                        state_d  = StIter;
                    end else begin
                        result_d = sc_result;
                        err_d    = sc_err;
                        eq_d     = (a_in == b_in);
                        done_d   = 1'b1;
                        state_d  = StFinish;
                    end
                end
            end
            StIter: begin
                eng_step = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last step: engine outputs already show the final value.
                    if (op_q == OP_MUL) begin
                        result_d = eng_product;
                    end else if (op_q == OP_DIVU) begin
                        result_d = eng_quotient;
                    end else begin
                        result_d = eng_remainder;
                    end
                    err_d   = 1'b0;
                    eq_d    = (a_q == b_q);
                    done_d  = 1'b1;
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            eq_q     <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            eq_q     <= eq_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;
    assign eq     = eq_q;
    assign err    = err_q;

endmodule
